// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, fetch step, reset vector
// and the {pc, instr} record carried through the IF/ID queue.
package cpu_pkg;

  localparam int          ADDR_W   = 32;
  localparam int          INSTR_W  = 32;
  localparam int          PC_STEP  = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage : cpu_pkg

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of fetch records with push/pop/flush and an occupancy count.
// The head is read combinationally from storage; the caller must gate it with
// count != 0 because unwritten slots are never cleared.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  entry_t        wr_data,
  output entry_t        rd_data,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state pointers and occupancy; flush empties the queue and rewinds both pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Pointer/count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; no reset so it maps onto distributed/block memory.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;

endmodule : fetch_fifo

// File: rtl/pipe_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the combinational instruction
// memory and queues {pc, instr} records for decode. Supports decode stall and
// branch/jump redirect (which flushes everything not consumed this cycle).
module pipe_fetch_unit #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INSTR_W  = cpu_pkg::INSTR_W,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = cpu_pkg::PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC),
  localparam int               CW       = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_stall,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_next,
  output logic [CW-1:0]      q_count
);

  // Local record type so non-default widths still pack correctly.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              push, pop;
  logic [CW-1:0]     count;
  entry_t            wr_entry, head;

  // Decode consumes the head unless stalled; fetch proceeds whenever a slot is
  // free or is being freed this cycle, and never during a redirect.
  assign pop  = id_valid & ~id_stall;
  assign push = ~redirect & ((count < DEPTH_C) | pop);

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = imem_instr;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (count)
  );

  // PC next-state: redirect reloads, a fetch advances by PC_STEP (wrapping), otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = redirect_pc;
    else if (push) pc_d = pc_q + STEP_C;
  end

  // PC register; reset takes priority over redirect and fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign imem_addr  = pc_q;
  assign q_count    = count;
  assign id_valid   = (count != '0);
  // Head fields are forced to zero when empty so stale storage never leaks out.
  assign id_instr   = id_valid ? head.instr     : '0;
  assign id_pc      = id_valid ? head.pc        : '0;
  assign id_pc_next = id_valid ? head.pc + STEP_C : '0;

endmodule : pipe_fetch_unit
